mult_arbiter: RTL and testbench
===============================

// Module: mult_arbiter
// PURPOSE
//  Shares one iterative 64-bit multiplier (mult) among NUM_REQ requesters, e.g. several ISR
//  square-root engines. Round-robin arbitration; one multiply in flight. Captures the
//  granted operands, sequences mult start/done, and returns the product to the owner.
// PARAMETERS
//  NUM_REQ   4    number of requesters (2..8)
//  ID_W      $clog2(NUM_REQ)  requester index width (derived, not overridden)
// PORTS
//  clock         in   1            single clock, rising edge
//  reset         in   1            synchronous, active-high
//  req           in   NUM_REQ      req[i]=1: requester i has valid operands; held until gnt[i]
//  mcand         in   NUM_REQ*64   packed operands, slice i = requester i
//  mplier        in   NUM_REQ*64   packed operands, slice i = requester i
//  gnt           out  NUM_REQ      one-hot, 1-cycle pulse: operands of i captured this cycle
//  resp_valid    out  NUM_REQ      one-hot, 1-cycle pulse: resp_product belongs to requester i
//  resp_product  out  64           low 64 bits of mcand*mplier; held until next resp_valid
//  busy          out  1            1 in any state other than IDLE
//  op_count      out  32           completed multiplies since reset, wraps at 2^32
// BEHAVIOUR
//  Reset: state IDLE, gnt=0, resp_valid=0, resp_product=0, busy=0, op_count=0, rr_ptr=0,
//   mult_start=0. Reset mid-operation discards the in-flight op with no resp_valid; the
//   same reset clears mult.
//  FSM IDLE -> ISSUE -> BUSY -> DRAIN -> IDLE.
//   IDLE: if |req at edge t, winner = first set bit at or after rr_ptr (circular). Latch
//    winner's operands and ID, go ISSUE. gnt[winner]=1 during cycle t+1 only.
//   ISSUE (1 cycle): mult_start=1, mult operands from latched regs. Next: BUSY.
//   BUSY: mult_start=0; wait for mult_done=1. Then register product into resp_product,
//    resp_valid[id]=1 next cycle, op_count+=1, rr_ptr=(id+1) mod NUM_REQ, go DRAIN.
//   DRAIN: mult_start=0; stay until mult_done=0 (mult done is level), then IDLE.
//  mult_done seen high in ISSUE is ignored (stale level from the previous op).
//  Latency: req seen at edge t -> gnt at t+1; resp_valid >= t+4 (mult time + 3).
//  No new grant while busy. Requests made meanwhile wait; arbitration uses rr_ptr at
//   re-entry to IDLE.
//  A requester holding req high in the gnt cycle is requesting a second, independent op.
//  req dropped before gnt: the request is withdrawn. No error is raised.
//  Operands, gnt and resp are only valid for the requester index shown. Other slices are
//   don't-care.
//  Width: operands are 64 bits; the product is truncated to the low 64 bits (same as mult).
//  op_count wraps 0xFFFF_FFFF -> 0 without a flag.
// STRUCTURE
//  Package mult_arb_pkg:
//   - typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DRAIN} arb_state_t
//   - localparam MAX_REQ=8, DATA_W=64
//  Sub-module: one rr_pick (NUM_REQ bits, combinational).
//   - Inputs: req, rr_ptr. Outputs: winner ID and found flag.
//  The top level instantiates one mult. Registered outputs only.
// TESTING
//  1 Single req[0], 3*5 -> gnt[0] one cycle later; resp_valid[0] with resp_product=15;
//    op_count=1.
//  2 req[1] and req[2] asserted together after reset -> grant order 1 then 2; products
//    are correct; no gnt during BUSY.
//  3 All 4 held high continuously for 8 ops -> grant order 0,1,2,3,0,1,2,3;
//    op_count=8.
//  4 0xFFFF_FFFF * 0xFFFF_FFFF -> resp_product=0xFFFF_FFFE_0000_0001; 0 * x -> 0.
//  5 reset pulsed in BUSY -> no resp_valid; all outputs at reset values next cycle;
//    new req[3] serviced normally.
//  6 req[0] dropped before gnt while another op is busy -> req[0] is never granted.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier arbiter: arbiter FSM states and the
// fixed widths of the multiplier datapath and the completion counter.
package mult_arb_pkg;

  localparam int MAX_REQ = 8;   // largest supported requester count
  localparam int DATA_W  = 64;  // operand and product width
  localparam int CNT_W   = 32;  // completed-operation counter width

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    DRAIN
  } arb_state_t;

endpackage

// File: rtl/mult.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// A start pulse loads the operands; DATA_W cycles later o_done rises and
// stays high for two cycles, then falls on its own. o_product holds the low
// DATA_W bits of the product until the next start.
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   i_start              load operands and begin a multiply
//   i_mcand, i_mplier    operands
//   o_product            low DATA_W bits of i_mcand * i_mplier
//   o_done               completion level
module mult
  import mult_arb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_mcand,
  input  logic [DATA_W-1:0] i_mplier,
  output logic [DATA_W-1:0] o_product,
  output logic              o_done
);

  localparam int STEP_W = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_acc;
  logic [STEP_W-1:0] r_steps;
  logic              r_done;
  logic              r_hold;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_steps <= '0;
      r_done  <= 1'b0;
      r_hold  <= 1'b0;
    end else if (i_start) begin
      r_a     <= i_mcand;
      r_b     <= i_mplier;
      r_acc   <= '0;
      r_steps <= STEP_W'(DATA_W);
      r_done  <= 1'b0;
      r_hold  <= 1'b0;
    end else if (r_steps != '0) begin
      if (r_b[0]) r_acc <= r_acc + r_a;
      r_a     <= r_a << 1;
      r_b     <= r_b >> 1;
      r_steps <= r_steps - 1'b1;
      if (r_steps == STEP_W'(1)) begin
        r_done <= 1'b1;
        r_hold <= 1'b1;
      end
    end else if (r_hold) begin
      r_hold <= 1'b0;
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_product = r_acc;
  assign o_done    = r_done;

endmodule

// File: rtl/mult_arbiter_rr_pick.sv
// Round-robin picker (combinational).
// Finds the first asserted request at or after i_rr_ptr, wrapping circularly.
// Ports:
//   i_req     requester valid bits
//   i_rr_ptr  highest-priority index for this pick
//   o_winner  index of the chosen requester (valid when o_found)
//   o_found   at least one request is asserted
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_rr_ptr,
  output logic [ID_W-1:0]    o_winner,
  output logic               o_found
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [ID_W-1:0]      w_off;
  logic [ID_W:0]        w_sum;

  // Rotate so that bit 0 of w_rot is the request at i_rr_ptr; the lowest set
  // bit of w_rot is then the winner's distance from the pointer.
  assign w_dbl = {i_req, i_req};
  assign w_rot = w_dbl[i_rr_ptr +: NUM_REQ];

  // NOTE: every variable written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_off   = '0;
    o_found = |w_rot;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = ID_W'(k);
    end
    w_sum    = {1'b0, i_rr_ptr} + {1'b0, w_off};
    o_winner = (w_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(w_sum - (ID_W+1)'(NUM_REQ))
                                             : w_sum[ID_W-1:0];
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one iterative multiplier among NUM_REQ requesters with round-robin
// arbitration and a single multiply in flight.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   req            per-requester valid, held until the matching gnt
//   mcand, mplier  packed operands, 64-bit slice i belongs to requester i
//   gnt            one-hot 1-cycle pulse: requester's operands were captured
//   resp_valid     one-hot 1-cycle pulse: resp_product belongs to that requester
//   resp_product   low 64 bits of the product, held until the next resp_valid
//   busy           high whenever the arbiter is not idle
//   op_count       completed multiplies since reset, wrapping
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] mcand,
  input  logic [NUM_REQ*DATA_W-1:0] mplier,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_product,
  output logic                      busy,
  output logic [CNT_W-1:0]          op_count
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("mult_arbiter: NUM_REQ must be in 2..MAX_REQ");
  end

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [DATA_W-1:0] r_resp_product;
  logic              r_busy;
  logic [CNT_W-1:0]  r_op_count;

  logic [ID_W-1:0]   w_winner;
  logic              w_found;
  logic              w_take;
  logic              w_finish;
  logic              w_mult_start;
  logic [DATA_W-1:0] w_mult_product;
  logic              w_mult_done;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_winner),
    .o_found  (w_found)
  );

  mult u_mult (
    .clock     (clock),
    .reset     (reset),
    .i_start   (w_mult_start),
    .i_mcand   (r_mcand),
    .i_mplier  (r_mplier),
    .o_product (w_mult_product),
    .o_done    (w_mult_done)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // mult_done is a level: in ISSUE it may still be high from the previous
  // multiply and is ignored; DRAIN waits for it to fall so the next operation
  // cannot mistake the old level for its own completion.
  always_comb begin
    w_state_nxt  = r_state;
    w_take       = 1'b0;
    w_finish     = 1'b0;
    w_mult_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_take      = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_mult_start = 1'b1;
        w_state_nxt  = BUSY;
      end
      BUSY: begin
        if (w_mult_done) begin
          w_finish    = 1'b1;
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!w_mult_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_id           <= '0;
      r_rr_ptr       <= '0;
      r_mcand        <= '0;
      r_mplier       <= '0;
      r_gnt          <= '0;
      r_resp_valid   <= '0;
      r_resp_product <= '0;
      r_busy         <= 1'b0;
      r_op_count     <= '0;
    end else begin
      r_gnt        <= '0;
      r_resp_valid <= '0;
      r_busy       <= (w_state_nxt != IDLE);
      if (w_take) begin
        r_id            <= w_winner;
        r_mcand         <= mcand[w_winner*DATA_W +: DATA_W];
        r_mplier        <= mplier[w_winner*DATA_W +: DATA_W];
        r_gnt[w_winner] <= 1'b1;
      end
      if (w_finish) begin
        r_resp_product     <= w_mult_product;
        r_resp_valid[r_id] <= 1'b1;
        r_op_count         <= r_op_count + 1'b1;
        r_rr_ptr           <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
      end
    end
  end

  assign gnt          = r_gnt;
  assign resp_valid   = r_resp_valid;
  assign resp_product = r_resp_product;
  assign busy         = r_busy;
  assign op_count     = r_op_count;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: each test task drives requesters and
// checks grants and responses against a behavioural round-robin model.
module tb_mult_arbiter;

  localparam int N = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*64-1:0] mcand = '0;
  logic [N*64-1:0] mplier = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    resp_valid;
  logic [63:0]     resp_product;
  logic            busy;
  logic [31:0]     op_count;

  mult_arbiter #(.NUM_REQ(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .mcand        (mcand),
    .mplier       (mplier),
    .gnt          (gnt),
    .resp_valid   (resp_valid),
    .resp_product (resp_product),
    .busy         (busy),
    .op_count     (op_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int          pending [N];
  logic [63:0] op_a    [N];
  logic [63:0] op_b    [N];
  int          model_ptr   = 0;
  int          model_count = 0;
  bit          in_flight   = 1'b0;
  int          exp_id      = 0;
  logic [63:0] exp_prod    = '0;
  int          done_ops    = 0;
  int          cyc         = 0;
  int          last_gnt_cyc = -1;
  int          grants_q[$];

  function automatic int model_pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (model_ptr + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic rand_ops(input int i);
    op_a[i] = {$urandom, $urandom};
    op_b[i] = {$urandom, $urandom};
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req[i]             = (pending[i] > 0);
      mcand[i*64 +: 64]  = op_a[i];
      mplier[i*64 +: 64] = op_b[i];
    end
  endtask

  // One clock: observe outputs mid-cycle, update the model, drive new inputs.
  task automatic step();
    logic [N-1:0] exp_vec;
    logic [N-1:0] want;
    int w;
    @(negedge clock);
    cyc++;
    if (gnt !== '0) begin
      last_gnt_cyc = cyc;
      w = model_pick(req);
      exp_vec = '0;
      if (w >= 0) exp_vec[w] = 1'b1;
      want = in_flight ? '0 : exp_vec;
      total++;
      if (gnt !== want) begin
        bad++;
        $display("FAIL gnt: got %b want %b (op in flight=%0d)", gnt, want, in_flight);
      end
      if (!in_flight && w >= 0) begin
        in_flight = 1'b1;
        exp_id    = w;
        exp_prod  = op_a[w] * op_b[w];
        grants_q.push_back(w);
        if (pending[w] > 0) pending[w]--;
        if (pending[w] > 0) rand_ops(w);
      end
    end
    if (resp_valid !== '0) begin
      exp_vec = '0;
      if (in_flight) exp_vec[exp_id] = 1'b1;
      total++;
      if (resp_valid !== exp_vec) begin
        bad++;
        $display("FAIL resp_valid: got %b want %b", resp_valid, exp_vec);
      end
      if (in_flight) begin
        total++;
        if (resp_product !== exp_prod) begin
          bad++;
          $display("FAIL resp_product: got %h want %h (req %0d)", resp_product, exp_prod, exp_id);
        end
        model_count++;
        total++;
        if (op_count !== 32'(model_count)) begin
          bad++;
          $display("FAIL op_count: got %0d want %0d", op_count, model_count);
        end
        model_ptr = (exp_id + 1) % N;
        in_flight = 1'b0;
        done_ops++;
      end
    end
    drive_inputs();
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int n = 0;
    while (done_ops < target && n < budget) begin
      step();
      n++;
    end
    total++;
    if (done_ops < target) begin
      bad++;
      $display("FAIL %s timeout: completed %0d want %0d", tag, done_ops, target);
    end
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (!in_flight && n < 20) begin
      step();
      n++;
    end
    total++;
    if (!in_flight) begin
      bad++;
      $display("FAIL %s: no grant within 20 cycles", tag);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < N; i++) pending[i] = 0;
    in_flight   = 1'b0;
    model_ptr   = 0;
    model_count = 0;
    drive_inputs();
    @(negedge clock);
    reset = 1'b0;
    total += 5;
    if (gnt !== '0)          begin bad++; $display("FAIL %s gnt: got %b want 0", tag, gnt); end
    if (resp_valid !== '0)   begin bad++; $display("FAIL %s resp_valid: got %b want 0", tag, resp_valid); end
    if (resp_product !== '0) begin bad++; $display("FAIL %s resp_product: got %h want 0", tag, resp_product); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL %s busy: got %b want 0", tag, busy); end
    if (op_count !== '0)     begin bad++; $display("FAIL %s op_count: got %0d want 0", tag, op_count); end
  endtask

  task automatic test_reset();
    do_reset("reset");
  endtask

  task automatic test_single();
    int t0;
    int base;
    do_reset("single_rst");
    op_a[0] = 64'd3;
    op_b[0] = 64'd5;
    pending[0] = 1;
    last_gnt_cyc = -1;
    base = done_ops;
    step();
    t0 = cyc;
    step();
    total++;
    if (last_gnt_cyc !== t0 + 1) begin
      bad++;
      $display("FAIL single latency: gnt at cycle %0d want %0d", last_gnt_cyc, t0 + 1);
    end
    step();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL single busy: got %b want 1", busy); end
    run_until(base + 1, 200, "single");
    total += 2;
    if (resp_product !== 64'd15) begin bad++; $display("FAIL single product: got %0d want 15", resp_product); end
    if (op_count !== 32'd1)      begin bad++; $display("FAIL single op_count: got %0d want 1", op_count); end
  endtask

  task automatic test_pair();
    int base;
    do_reset("pair_rst");
    rand_ops(1);
    rand_ops(2);
    pending[1] = 1;
    pending[2] = 1;
    grants_q.delete();
    base = done_ops;
    run_until(base + 2, 400, "pair");
    total++;
    if (grants_q.size() != 2 || grants_q[0] != 1 || grants_q[1] != 2) begin
      bad++;
      $display("FAIL pair order: got %p want '{1, 2}", grants_q);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset("rr_rst");
    for (int i = 0; i < N; i++) begin
      rand_ops(i);
      pending[i] = 2;
    end
    grants_q.delete();
    base = done_ops;
    run_until(base + 8, 1200, "rr");
    for (int k = 0; k < 8; k++) begin
      total++;
      if (k >= grants_q.size() || grants_q[k] != k % N) begin
        bad++;
        $display("FAIL rr grant %0d: got %0d want %0d", k,
                 (k < grants_q.size()) ? grants_q[k] : -1, k % N);
      end
    end
    total++;
    if (op_count !== 32'd8) begin bad++; $display("FAIL rr op_count: got %0d want 8", op_count); end
  endtask

  task automatic test_wide();
    int base;
    op_a[2] = 64'h0000_0000_FFFF_FFFF;
    op_b[2] = 64'h0000_0000_FFFF_FFFF;
    pending[2] = 1;
    base = done_ops;
    run_until(base + 1, 200, "wide_max");
    total++;
    if (resp_product !== 64'hFFFF_FFFE_0000_0001) begin
      bad++;
      $display("FAIL wide_max product: got %h want fffffffe00000001", resp_product);
    end
    op_a[1] = '0;
    op_b[1] = {$urandom, $urandom};
    pending[1] = 1;
    run_until(base + 2, 200, "wide_zero");
    total++;
    if (resp_product !== 64'd0) begin
      bad++;
      $display("FAIL wide_zero product: got %h want 0", resp_product);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    rand_ops(1);
    pending[1] = 1;
    wait_grant("reset_mid_grant");
    repeat (10) step();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL reset_mid busy before reset: got %b want 1", busy); end
    do_reset("reset_mid");
    repeat (100) step();
    total++;
    if (op_count !== 32'd0) begin bad++; $display("FAIL reset_mid stale op: op_count %0d want 0", op_count); end
    rand_ops(3);
    pending[3] = 1;
    grants_q.delete();
    base = done_ops;
    run_until(base + 1, 200, "reset_mid_req3");
    total++;
    if (grants_q.size() != 1 || grants_q[0] != 3 || op_count !== 32'd1) begin
      bad++;
      $display("FAIL reset_mid req3: grants %p op_count %0d want '{3} and 1", grants_q, op_count);
    end
  endtask

  task automatic test_withdraw();
    int base;
    int zero_grants = 0;
    rand_ops(2);
    pending[2] = 1;
    grants_q.delete();
    base = done_ops;
    wait_grant("withdraw_grant");
    rand_ops(0);
    pending[0] = 1;
    repeat (10) step();
    pending[0] = 0;
    run_until(base + 1, 200, "withdraw");
    repeat (30) step();
    foreach (grants_q[k]) if (grants_q[k] == 0) zero_grants++;
    total++;
    if (zero_grants != 0 || grants_q.size() != 1) begin
      bad++;
      $display("FAIL withdraw: grants %p want only '{2}", grants_q);
    end
  endtask

  task automatic test_random();
    int base;
    int r;
    base = done_ops;
    for (int k = 0; k < 6; k++) begin
      r = int'($urandom_range(0, N - 1));
      if (pending[r] == 0) rand_ops(r);
      pending[r]++;
      repeat ($urandom_range(0, 40)) step();
    end
    run_until(base + 6, 1500, "random");
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pending[i] = 0;
      op_a[i] = '0;
      op_b[i] = '0;
    end
    test_reset();
    test_single();
    test_pair();
    test_back_to_back();
    test_wide();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
